scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 2, select width; SHALL support 1..6, output width 2**N.
REQ-002 Parameter ACTIVE_LOW, default 0; 1 SHALL invert Y at the output only; DONE and POS are unaffected.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 A  input  N  select / scan start position.
REQ-006 E  input  1  enable, active-high.
REQ-007 MODE  input  2  00 DIRECT, 01 SCAN, 10 HOLD, 11 reserved.
REQ-008 Y  output  2**N  registered one-hot (or all-zero) decode, polarity per ACTIVE_LOW.
REQ-009 POS  output  N  registered current decoded position.
REQ-010 DONE  output  1  registered single-cycle scan-complete pulse.

Function
REQ-011 FSM states SHALL be IDLE, SCAN and WAIT, with a counter cnt of N+1 bits.
REQ-012 IDLE, MODE=00: Y<=onehot(A) if E=1, else all-zero; POS<=A; latency exactly 1 cycle.
REQ-013 IDLE, MODE=01, E=1: POS<=A, cnt<=0, Y<=onehot(A), next state SCAN.
REQ-014 IDLE, MODE=01, E=0: Y<=all-zero, POS holds, state stays IDLE.
REQ-015 IDLE, MODE=10: Y and POS SHALL hold their current values regardless of E and A.
REQ-016 IDLE, MODE=11: Y<=all-zero, POS holds.
REQ-017 SCAN, MODE=01, E=1, cnt<2**N-1: POS<=(POS+1) mod 2**N, Y<=onehot(POS+1), cnt<=cnt+1.
REQ-018 POS wrap-around from 2**N-1 to 0 SHALL be seamless, with no gap cycle.
REQ-019 SCAN, cnt=2**N-1 (last position shown): DONE<=1, Y<=all-zero, next state WAIT; exactly 2**N positions SHALL be shown, one cycle each.
REQ-020 SCAN, E=0 or MODE!=01 (abort): Y<=all-zero, DONE stays 0, next state IDLE; abort SHALL take priority over completion in the same cycle.
REQ-021 WAIT: Y all-zero, DONE<=0 after its single cycle; exit to IDLE only when E=0 or MODE!=01, so a held SCAN request SHALL NOT restart.
REQ-022 A changes during SCAN SHALL be ignored.
REQ-023 DONE SHALL be high for exactly one cycle per completed scan.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, cnt=0, POS=0 and DONE=0, without waiting for clk.
REQ-025 rst=1 SHALL immediately force Y to all-zero (all-ones when ACTIVE_LOW=1).
REQ-026 Reset asserted mid-scan SHALL abandon the scan without a DONE pulse.
REQ-027 The first edge after reset release SHALL follow the IDLE rules.

Structure
REQ-028 Package scan_decoder_pkg SHALL hold the state enum and the MODE constants (MODE_DIRECT, MODE_SCAN, MODE_HOLD, MODE_RSVD).
REQ-029 A combinational sub-module onehot_dec (parameter N; in N bits, out 2**N bits) SHALL perform all decoding; all registers SHALL reside in scan_decoder.

Verification
REQ-030 N=2, DIRECT: E=1, A=01 -> Y=0010 one cycle later; then E=0 -> Y=0000 next cycle.
REQ-031 N=2, SCAN, A=10, E=1 held -> Y=0100,1000,0001,0010 on successive cycles; next cycle DONE=1, Y=0000; no restart while E stays 1.
REQ-032 N=2, SCAN started at A=00, E dropped after 2 positions -> Y=0000 next cycle, DONE never asserted.
REQ-033 N=2, HOLD after DIRECT with A=11 -> Y stays 1000 while A toggles.
REQ-034 N=3, ACTIVE_LOW=1, rst pulsed between edges mid-scan -> Y=11111111, POS=000, DONE=0 immediately; scan does not resume.
REQ-035 N=3, SCAN from A=111 -> POS 111,000,...,110, then DONE pulses once.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder: FSM states and MODE encodings.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // A scan is requested (or kept alive) only while enabled in SCAN mode.
    function automatic logic is_scan_req(input logic e, input logic [1:0] mode);
        return e && (mode == MODE_SCAN);
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Purely combinational N-to-2**N one-hot decoder; holds no state.
module onehot_dec #(
    parameter int N = 2
) (
    input  logic [N-1:0]      din,
    output logic [2**N-1:0]   dout
);

    // Clear every line, then raise the single line selected by din.
    always_comb begin
        dout       = '0;
        dout[din]  = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered decoder with DIRECT, SCAN and HOLD modes; output polarity set by ACTIVE_LOW.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      A,
    input  logic              E,
    input  logic [1:0]        MODE,
    output logic [2**N-1:0]   Y,
    output logic [N-1:0]      POS,
    output logic              DONE
);

    localparam int         W        = 2**N;
    localparam logic [N:0] LAST_CNT = (N+1)'(W - 1);

    state_e         state_q, state_d;
    logic [N:0]     cnt_q,   cnt_d;
    logic [N-1:0]   pos_q,   pos_d;
    logic [W-1:0]   y_q,     y_d;
    logic           done_q,  done_d;

    logic [N-1:0]   pos_inc;
    logic [N-1:0]   dec_sel;
    logic [W-1:0]   dec_out;
    logic           scan_req;

    // Position increment wraps naturally at N bits, so 2**N-1 -> 0 needs no gap cycle.
    assign pos_inc  = pos_q + N'(1);
    assign scan_req = is_scan_req(E, MODE);

    // While scanning the decoder looks one step ahead; otherwise it decodes A.
    assign dec_sel = (state_q == ST_SCAN) ? pos_inc : A;

    onehot_dec #(.N(N)) u_dec (
        .din  (dec_sel),
        .dout (dec_out)
    );

    // Next-state and next-output logic; every register holds unless a rule changes it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        y_d     = y_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                case (MODE)
                    MODE_DIRECT: begin
                        y_d   = E ? dec_out : '0;
                        pos_d = A;
                    end
                    MODE_SCAN: begin
                        if (E) begin
                            y_d     = dec_out;
                            pos_d   = A;
                            cnt_d   = '0;
                            state_d = ST_SCAN;
                        end else begin
                            y_d = '0;
                        end
                    end
                    MODE_HOLD: begin
                        y_d   = y_q;
                        pos_d = pos_q;
                    end
                    MODE_RSVD: begin
                        y_d = '0;
                    end
                    default: begin
                        y_d = '0;
                    end
                endcase
            end

            ST_SCAN: begin
                if (!scan_req) begin
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    y_d     = '0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    y_d   = dec_out;
                    pos_d = pos_inc;
                    cnt_d = cnt_q + (N+1)'(1);
                end
            end

            ST_WAIT: begin
                y_d = '0;
                if (!scan_req) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                y_d     = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset acts immediately and clears any scan in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    // Polarity inversion is applied only to Y, after the register.
    assign Y    = ACTIVE_LOW ? ~y_q : y_q;
    assign POS  = pos_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench: one N=2 active-high decoder and one N=3 active-low decoder side by side.
module tb_scan_decoder;

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_SCAN   = 2'b01;
    localparam logic [1:0] M_HOLD   = 2'b10;
    localparam logic [1:0] M_RSVD   = 2'b11;

    logic       clk;
    logic       rst;
    logic [1:0] a2;
    logic       e2;
    logic [1:0] mode2;
    logic [3:0] y2;
    logic [1:0] pos2;
    logic       done2;
    logic [2:0] a3;
    logic       e3;
    logic [1:0] mode3;
    logic [7:0] y3;
    logic [2:0] pos3;
    logic       done3;

    int vectors;
    int miscompares;

    // Reference model, index 0 = N=2 instance, index 1 = N=3 instance.
    int m_y[2];
    int m_pos[2];
    int m_done[2];
    int m_scan[2];
    int m_wait[2];
    int m_shown[2];

    scan_decoder #(.N(2), .ACTIVE_LOW(1'b0)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .A    (a2),
        .E    (e2),
        .MODE (mode2),
        .Y    (y2),
        .POS  (pos2),
        .DONE (done2)
    );

    scan_decoder #(.N(3), .ACTIVE_LOW(1'b1)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .A    (a3),
        .E    (e3),
        .MODE (mode3),
        .Y    (y3),
        .POS  (pos3),
        .DONE (done3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_y[i]     = 0;
            m_pos[i]   = 0;
            m_done[i]  = 0;
            m_scan[i]  = 0;
            m_wait[i]  = 0;
            m_shown[i] = 0;
        end
    endtask

    // One clock edge of behaviour: a scan shows 2**n consecutive positions, then a done pulse.
    task automatic modelStep(input int i, input int n, input int a, input int e, input int mode);
        int size;
        int keep;
        size      = 1 << n;
        keep      = (e != 0) && (mode == 1);
        m_done[i] = 0;
        if (m_scan[i] != 0) begin
            if (keep == 0) begin
                m_scan[i] = 0;
                m_y[i]    = 0;
            end else if (m_shown[i] < size) begin
                m_pos[i]   = (m_pos[i] + 1) % size;
                m_y[i]     = 1 << m_pos[i];
                m_shown[i] = m_shown[i] + 1;
            end else begin
                m_done[i] = 1;
                m_y[i]    = 0;
                m_scan[i] = 0;
                m_wait[i] = 1;
            end
        end else if (m_wait[i] != 0) begin
            m_y[i] = 0;
            if (keep == 0) m_wait[i] = 0;
        end else begin
            case (mode)
                0: begin
                    m_y[i]   = (e != 0) ? (1 << a) : 0;
                    m_pos[i] = a;
                end
                1: begin
                    if (e != 0) begin
                        m_pos[i]   = a;
                        m_y[i]     = 1 << a;
                        m_shown[i] = 1;
                        m_scan[i]  = 1;
                    end else begin
                        m_y[i] = 0;
                    end
                end
                2: ;
                default: m_y[i] = 0;
            endcase
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs of both instances against the model.
    task automatic checkOutput(input string tag);
        checkVal({tag, "_y2"},    32'(y2),    32'(m_y[0] & 32'hF));
        checkVal({tag, "_pos2"},  32'(pos2),  32'(m_pos[0]));
        checkVal({tag, "_done2"}, 32'(done2), 32'(m_done[0]));
        checkVal({tag, "_y3"},    32'(y3),    32'((~m_y[1]) & 32'hFF));
        checkVal({tag, "_pos3"},  32'(pos3),  32'(m_pos[1]));
        checkVal({tag, "_done3"}, 32'(done3), 32'(m_done[1]));
    endtask

    // Drive both instances for one cycle, advance the model, and check just after the edge.
    task automatic applyStimulus(input int na2, input int ne2, input int nm2,
                                 input int na3, input int ne3, input int nm3,
                                 input string tag);
        a2    = 2'(na2);
        e2    = 1'(ne2);
        mode2 = 2'(nm2);
        a3    = 3'(na3);
        e3    = 1'(ne3);
        mode3 = 2'(nm3);
        @(posedge clk);
        modelStep(0, 2, na2, ne2, nm2);
        modelStep(1, 3, na3, ne3, nm3);
        #1;
        checkOutput(tag);
    endtask

    // Mid-cycle asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic pulseReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b0;
        a2    = '0;
        e2    = 1'b0;
        mode2 = M_HOLD;
        a3    = '0;
        e3    = 1'b0;
        mode3 = M_HOLD;
        modelReset();

        // Reset asserted between edges takes effect at once.
        #1;
        rst = 1'b1;
        #1;
        checkOutput("reset");
        checkVal("reset_y3_all_ones", 32'(y3), 32'hFF);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // DIRECT: A=01 -> 0010, then E=0 -> 0000.
        applyStimulus(1, 1, 0, 0, 0, 2, "direct_on");
        checkVal("direct_on_lit", 32'(y2), 32'h2);
        applyStimulus(1, 0, 0, 0, 0, 2, "direct_off");
        checkVal("direct_off_lit", 32'(y2), 32'h0);

        // Concurrent scans: N=2 from A=10 and N=3 from A=111, SCAN request held throughout.
        for (int k = 0; k < 11; k++) begin
            applyStimulus(2, 1, 1, 7, 1, 1, "scan_held");
            if (k < 4) checkVal("scan2_y_lit", 32'(y2), 32'(1 << ((2 + k) % 4)));
            if (k == 4) checkVal("scan2_done_lit", 32'(done2), 32'h1);
            if (k > 4) checkVal("scan2_norestart_lit", 32'(y2), 32'h0);
            if (k < 8) checkVal("scan3_pos_lit", 32'(pos3), 32'((7 + k) % 8));
            if (k == 8) checkVal("scan3_done_lit", 32'(done3), 32'h1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, "leave_wait");

        // Abort after two positions: Y clears, no done pulse.
        applyStimulus(0, 1, 1, 0, 0, 2, "abort_p0");
        applyStimulus(0, 1, 1, 0, 0, 2, "abort_p1");
        applyStimulus(0, 0, 1, 0, 0, 2, "abort_drop");
        checkVal("abort_y_lit", 32'(y2), 32'h0);
        checkVal("abort_done_lit", 32'(done2), 32'h0);
        applyStimulus(0, 0, 1, 0, 0, 2, "abort_after");

        // HOLD after DIRECT A=11 keeps 1000 while A toggles; reserved mode clears Y.
        applyStimulus(3, 1, 0, 0, 0, 2, "hold_load");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k, k % 2, 2, 0, 0, 2, "hold");
            checkVal("hold_y_lit", 32'(y2), 32'h8);
        end
        applyStimulus(1, 1, 3, 5, 1, 3, "rsvd");

        // N=3 scan interrupted by asynchronous reset, A changes ignored mid-scan.
        applyStimulus(0, 0, 2, 2, 1, 1, "rst_scan0");
        applyStimulus(0, 0, 2, 6, 1, 1, "rst_scan1");
        applyStimulus(0, 0, 2, 1, 1, 1, "rst_scan2");
        pulseReset("rst_mid");
        checkVal("rst_mid_y3_lit", 32'(y3), 32'hFF);
        checkVal("rst_mid_pos3_lit", 32'(pos3), 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 2, 4, 0, 1, "rst_after");
            checkVal("rst_after_done3_lit", 32'(done3), 32'h0);
        end

        // Randomised traffic biased towards held scans, with occasional async resets.
        for (int k = 0; k < 600; k++) begin
            int r2;
            int r3;
            int md2;
            int md3;
            r2  = int'($urandom_range(0, 9));
            r3  = int'($urandom_range(0, 9));
            md2 = (r2 < 5) ? 1 : (r2 < 7) ? 0 : (r2 < 9) ? 2 : 3;
            md3 = (r3 < 6) ? 1 : (r3 < 8) ? 0 : (r3 < 9) ? 2 : 3;
            applyStimulus(int'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0) ? 1 : 0, md2,
                          int'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0) ? 1 : 0, md3,
                          "random");
            if ($urandom_range(0, 49) == 0) pulseReset("random_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
